bb_sample_streamer: RTL and testbench
=====================================

BB_SAMPLE_STREAMER -- requirements
Module: bb_sample_streamer

Interface
REQ-001 SHALL have parameter IO_READWIDTH, default 16: bits per channel sample.
REQ-002 SHALL have parameter NUM_CH, default 2: channels packed per sample word, channel 0 in LSBs.
REQ-003 SHALL have parameter DEPTH, default 1024 (power of 2): sample words stored; AW = log2(DEPTH).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: load_valid  in  1; load_data  in  NUM_CH*IO_READWIDTH; load_ready  out  1  (load handshake).
REQ-006 SHALL have ports: cfg_len  in  AW+1  samples per pass; cfg_loop  in  1  1=loop, 0=one-shot; start  in  1; stop  in  1; clear  in  1.
REQ-007 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  NUM_CH*IO_READWIDTH; out_last  out  1  last sample of a pass.
REQ-008 SHALL have ports: fill  out  AW+1  words loaded; busy  out  1; done  out  1  pulse; err  out  1  pulse.

Function
REQ-009 SHALL implement FSM states IDLE, PLAY, FINISH; busy = (state != IDLE).
REQ-010 SHALL assert load_ready only in IDLE with fill < DEPTH; load_valid & load_ready writes mem[fill], fill increments.
REQ-011 SHALL hold load_ready low at fill == DEPTH; no write, no wrap.
REQ-012 SHALL, on clear in IDLE, set fill to 0; clear outside IDLE is ignored; clear with a load beat in the same cycle: clear wins, no write.
REQ-013 SHALL, on start in IDLE with 1 <= cfg_len <= fill, latch cfg_len and cfg_loop, enter PLAY next cycle; otherwise pulse err one cycle, stay IDLE.
REQ-014 SHALL ignore start outside IDLE and start with clear together (clear wins, err not asserted).
REQ-015 SHALL read addresses 0..len-1 in order from a synchronous 1-cycle-latency RAM; first out_valid at most 3 cycles after start.
REQ-016 SHALL obey ready/valid: out_data/out_last stable while out_valid & !out_ready; one word transferred per cycle when out_ready held high (no bubbles after first word).
REQ-017 SHALL assert out_last with word len-1; with len == 1 every word carries out_last.
REQ-018 SHALL, in loop mode, wrap address len-1 -> 0 with no bubble.
REQ-019 SHALL, in one-shot mode, enter FINISH after the out_last word is accepted.
REQ-020 SHALL latch stop in PLAY as pending; current pass completes, FINISH after its out_last accepted; stop in IDLE ignored.
REQ-021 SHALL pulse done one cycle in FINISH, then return to IDLE; out_valid low in FINISH and IDLE.
REQ-022 SHALL discard prefetched words on entering FINISH; no partial pass emitted.

Reset
REQ-023 SHALL on rst_n low asynchronously set state IDLE, fill 0, out_valid 0, out_last 0, out_data 0, done 0, err 0, stop-pending 0, read pointers 0.
REQ-024 SHALL not reset RAM contents; reset mid-PLAY aborts with no done pulse, data unreadable until reloaded (fill 0).

Configuration
REQ-025 SHALL, with BB_STREAMER_STATS_EN defined, add port pass_cnt out 16: completed passes since start, cleared on start, saturating at 0xFFFF, reset 0.
REQ-026 SHALL, without BB_STREAMER_STATS_EN, omit pass_cnt and its counter; other behaviour identical.

Structure
REQ-027 SHALL place the FSM state enum and the BB_STREAMER_CNT_W = 16 constant in package bb_streamer_pkg.
REQ-028 SHALL instantiate the storage as sub-module bb_sample_ram (1 write, 1 read port, registered read, no reset).

Verification
REQ-029 SHALL cover: load 4 words 0x0001_0002..0x0007_0008, cfg_len=4, one-shot, out_ready=1 -> 4 words in order, out_last on 4th, done 1 cycle later, busy low after.
REQ-030 SHALL cover: DEPTH=8, 10 load beats -> load_ready low after 8th, fill=8, beats 9-10 not written.
REQ-031 SHALL cover: fill=3, start with cfg_len=5 -> err pulse, busy stays 0; cfg_len=0 -> err pulse.
REQ-032 SHALL cover: loop, cfg_len=3, stop after 5 words accepted -> words 6 (out_last) then done; 6 words total; pass_cnt=2 when stats enabled.
REQ-033 SHALL cover: random out_ready toggling, cfg_len=16 loop, 3 passes -> data stable during stalls, sequence matches memory, no gaps with ready high.
REQ-034 SHALL cover: rst_n low mid-PLAY -> out_valid 0 and fill 0 immediately, no done pulse; reload and replay correct.

Source files
------------

// File: rtl/bb_streamer_pkg.sv
// bb_streamer_pkg
//   Shared definitions for the baseband sample streamer:
//     state_t           - playback FSM encoding (IDLE, PLAY, FINISH)
//     BB_STREAMER_CNT_W - width of the optional completed-pass counter
package bb_streamer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int unsigned BB_STREAMER_CNT_W = 16;

endpackage

// File: rtl/bb_sample_ram.sv
// bb_sample_ram
//   Simple dual-port sample store: one synchronous write port and one
//   registered read port (1-cycle latency). The read register only updates
//   when re is high, so a stalled consumer sees stable rdata. No reset on
//   contents or the read register.
//   Ports:
//     clk           - clock
//     we/waddr/wdata - write port
//     re/raddr      - read enable / address
//     rdata         - registered read data
module bb_sample_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/bb_sample_streamer.sv
// bb_sample_streamer
//   Loads packed multi-channel sample words into a local RAM, then plays
//   the first cfg_len words out over a ready/valid stream, either once or
//   looping until a stop request lets the current pass finish.
//   Ports:
//     clk, rst_n                       - clock, async active-low reset
//     load_valid/load_data/load_ready  - load handshake (IDLE only)
//     cfg_len, cfg_loop                - pass length, loop/one-shot select
//     start, stop, clear               - control strobes
//     out_valid/out_ready/out_data/out_last - output stream
//     fill                             - words currently loaded
//     busy, done, err                  - status (done/err are pulses)
//     pass_cnt                         - completed passes since start,
//                                        present only with
//                                        BB_STREAMER_STATS_EN defined
module bb_sample_streamer
    import bb_streamer_pkg::*;
#(
    parameter int unsigned IO_READWIDTH = 16,
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DEPTH        = 1024,
    localparam int unsigned AW          = $clog2(DEPTH),
    localparam int unsigned DW          = NUM_CH * IO_READWIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    input  logic [AW:0]   cfg_len,
    input  logic          cfg_loop,
    input  logic          start,
    input  logic          stop,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [AW:0]   fill,
    output logic          busy,
    output logic          done,
    output logic          err
`ifdef BB_STREAMER_STATS_EN
    ,
    output logic [BB_STREAMER_CNT_W-1:0] pass_cnt
`endif
);

    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t        state, state_nxt;
    logic [AW:0]   len_q;
    logic          loop_q;
    logic          stop_pend;
    logic [AW-1:0] rd_ptr;
    logic          gen_on;
    logic          s1_valid;
    logic          s1_last;
    logic [DW-1:0] ram_rdata;
    logic          wr_en;
    logic          start_ok;
    logic          start_go;
    logic          ptr_at_end;
    logic          accept;
    logic          advance;
    logic          finish_go;

    assign load_ready = (state == IDLE) && (fill != FULL);
    assign wr_en      = load_valid && load_ready && !clear;
    assign start_ok   = (cfg_len != '0) && (cfg_len <= fill);
    assign start_go   = (state == IDLE) && start && !clear && start_ok;
    assign ptr_at_end = ({1'b0, rd_ptr} == (len_q - LEN_ONE));
    assign accept     = out_valid && out_ready;
    // Two-stage pipeline (RAM register, output register) that stalls as a
    // whole; the RAM read register holds while re is low.
    assign advance    = (state == PLAY) && (!out_valid || out_ready);
    // A stop arriving in the same cycle as the final accept still counts.
    assign finish_go  = (state == PLAY) && accept && out_last &&
                        (!loop_q || stop_pend || stop);

    bb_sample_ram #(
        .WIDTH (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (fill[AW-1:0]),
        .wdata (load_data),
        .re    (advance && gen_on),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FINISH);
        case (state)
            IDLE:    if (start_go)  state_nxt = PLAY;
            PLAY:    if (finish_go) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill      <= '0;
            len_q     <= '0;
            loop_q    <= 1'b0;
            stop_pend <= 1'b0;
            rd_ptr    <= '0;
            gen_on    <= 1'b0;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            err       <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear) begin
                        fill <= '0;
                    end else begin
                        if (wr_en) begin
                            fill <= fill + LEN_ONE;
                        end
                        if (start) begin
                            if (start_ok) begin
                                len_q     <= cfg_len;
                                loop_q    <= cfg_loop;
                                rd_ptr    <= '0;
                                gen_on    <= 1'b1;
                                s1_valid  <= 1'b0;
                                stop_pend <= 1'b0;
                            end else begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                PLAY: begin
                    if (stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (finish_go) begin
                        // Drop anything prefetched beyond the finished pass.
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        s1_valid  <= 1'b0;
                        gen_on    <= 1'b0;
                    end else if (advance) begin
                        out_valid <= s1_valid;
                        out_last  <= s1_valid && s1_last;
                        if (s1_valid) begin
                            out_data <= ram_rdata;
                        end
                        s1_valid <= gen_on;
                        s1_last  <= ptr_at_end;
                        if (gen_on) begin
                            rd_ptr <= ptr_at_end ? '0 : rd_ptr + PTR_ONE;
                            if (ptr_at_end && !loop_q) begin
                                gen_on <= 1'b0;
                            end
                        end
                    end
                end
                FINISH: begin
                    stop_pend <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef BB_STREAMER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
        end else if (start_go) begin
            pass_cnt <= '0;
        end else if ((state == PLAY) && accept && out_last && (pass_cnt != '1)) begin
            pass_cnt <= pass_cnt + BB_STREAMER_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_bb_sample_streamer.sv
// tb_bb_sample_streamer
//   Directed bench for bb_sample_streamer. Main instance uses DEPTH=16,
//   a second DEPTH=8 instance exercises the full-store boundary.
//   Build with BB_STREAMER_STATS_EN defined to also check pass_cnt.
module tb_bb_sample_streamer;

    localparam int unsigned DW   = 32;
    localparam int unsigned DEP  = 16;
    localparam int unsigned AW   = 4;
    localparam int unsigned SDEP = 8;
    localparam int unsigned SAW  = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data  = '0;
    logic          load_ready;
    logic [AW:0]   cfg_len    = '0;
    logic          cfg_loop   = 1'b0;
    logic          start      = 1'b0;
    logic          stop       = 1'b0;
    logic          clear      = 1'b0;
    logic          out_valid;
    logic          out_ready  = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [AW:0]   fill;
    logic          busy, done, err;

    logic          s_load_valid = 1'b0;
    logic [DW-1:0] s_load_data  = '0;
    logic          s_load_ready;
    logic [SAW:0]  s_cfg_len    = '0;
    logic          s_start      = 1'b0;
    logic          s_out_valid;
    logic          s_out_ready  = 1'b0;
    logic [DW-1:0] s_out_data;
    logic          s_out_last;
    logic [SAW:0]  s_fill;
    logic          s_busy, s_done, s_err;

`ifdef BB_STREAMER_STATS_EN
    logic [15:0] pass_cnt, s_pass_cnt;
`endif

    bb_sample_streamer #(.IO_READWIDTH(16), .NUM_CH(2), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .cfg_len(cfg_len), .cfg_loop(cfg_loop), .start(start), .stop(stop), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .fill(fill), .busy(busy), .done(done), .err(err)
`ifdef BB_STREAMER_STATS_EN
        , .pass_cnt(pass_cnt)
`endif
    );

    bb_sample_streamer #(.IO_READWIDTH(16), .NUM_CH(2), .DEPTH(SDEP)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .load_valid(s_load_valid), .load_data(s_load_data), .load_ready(s_load_ready),
        .cfg_len(s_cfg_len), .cfg_loop(1'b0), .start(s_start), .stop(1'b0), .clear(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
        .fill(s_fill), .busy(s_busy), .done(s_done), .err(s_err)
`ifdef BB_STREAMER_STATS_EN
        , .pass_cnt(s_pass_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model [DEP];
    logic [DW-1:0] acc_data [$];
    logic          acc_last [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_fill", fill, 0);
    endtask

    task automatic load_words(input int n, input logic [DW-1:0] base, input logic [DW-1:0] inc);
        for (int i = 0; i < n; i++) begin
            load_data = base + inc * i;
            model[i]  = load_data;
            check("load_ready", load_ready, 1);
            load_valid = 1'b1;
            step();
        end
        load_valid = 1'b0;
        check("load_fill", fill, n);
    endtask

    task automatic start_play(input int len, input logic loop);
        cfg_len  = (AW+1)'(len);
        cfg_loop = loop;
        start    = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", busy, 1);
    endtask

    // rmode 0: out_ready held high; 1: random out_ready.
    // stop is pulsed in the cycle after the stop_after-th word is accepted.
    task automatic run_stream(input int len, input int exp_total, input int rmode,
                              input int stop_after, input int budget);
        int n_acc = 0;
        int cyc = 0;
        int first = -1;
        bit got_done = 0;
        bit prev_stall = 0;
        bit prev_ready = 0;
        bit stop_next = 0;
        logic [DW-1:0] prev_data = '0;
        logic prev_last = 1'b0;
        acc_data.delete();
        acc_last.delete();
        while (!got_done && cyc < budget) begin
            stop      = stop_next;
            stop_next = 0;
            if (done) begin
                got_done = 1;
                check("finish_out_valid", out_valid, 0);
            end else begin
                if (out_valid && first < 0) first = cyc;
                if (prev_stall) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, prev_data);
                    check("stall_last", out_last, prev_last);
                end
                if (prev_ready && first >= 0 && n_acc < exp_total)
                    check("no_bubble", out_valid, 1);
                out_ready = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                if (out_valid && out_ready) begin
                    acc_data.push_back(out_data);
                    acc_last.push_back(out_last);
                    n_acc++;
                    if (n_acc == stop_after) stop_next = 1;
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                prev_ready = out_ready;
                step();
                cyc++;
            end
        end
        stop = 1'b0;
        if (!got_done) check("done_timeout", 0, 1);
        check("first_latency_le3", (first >= 0) && (first <= 3), 1);
        check("word_count", n_acc, exp_total);
        for (int k = 0; k < n_acc && k < exp_total; k++) begin
            check("word_data", acc_data[k], model[k % len]);
            check("word_last", acc_last[k], (k % len) == (len - 1));
        end
        step();
        check("done_one_cycle", done, 0);
        check("busy_after", busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_fill", fill, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_load_ready", load_ready, 1);
        rst_n = 1'b1;
        step();

        // One-shot pass of 4 words, ready always high.
        do_clear();
        load_words(4, 32'h0001_0002, 32'h0002_0002);
        check("model_w3", model[3], 32'h0007_0008);
        start_play(4, 1'b0);
        run_stream(4, 4, 0, 0, 40);

        // Full store on DEPTH=8: beats 9 and 10 must be refused.
        for (int i = 0; i < 10; i++) begin
            s_load_data = 32'hA000_0000 + DW'(i);
            check("s_load_ready", s_load_ready, i < 8);
            s_load_valid = 1'b1;
            step();
        end
        s_load_valid = 1'b0;
        check("s_fill_full", s_fill, 8);
        check("s_load_ready_full", s_load_ready, 0);
        s_cfg_len   = 4'd8;
        s_out_ready = 1'b1;
        s_start     = 1'b1;
        step();
        s_start = 1'b0;
        begin
            int w = 0;
            while (!s_out_valid && w < 5) begin
                step();
                w++;
            end
        end
        check("s_first_valid", s_out_valid, 1);
        for (int i = 0; i < 8; i++) begin
            check("s_word_data", s_out_data, 32'hA000_0000 + DW'(i));
            check("s_word_last", s_out_last, i == 7);
            step();
        end
        check("s_done", s_done, 1);
        step();
        check("s_busy_after", s_busy, 0);

        // Length errors and start/clear collisions.
        do_clear();
        load_words(3, 32'h0300_0000, 32'h1);
        cfg_len = 5'd5; start = 1'b1; step(); start = 1'b0;
        check("err_len_gt_fill", err, 1);
        check("err_busy", busy, 0);
        step();
        check("err_one_cycle", err, 0);
        cfg_len = 5'd0; start = 1'b1; step(); start = 1'b0;
        check("err_len_zero", err, 1);
        check("err0_busy", busy, 0);
        step();
        cfg_len = 5'd2; start = 1'b1; clear = 1'b1; step(); start = 1'b0; clear = 1'b0;
        check("start_clear_err", err, 0);
        check("start_clear_busy", busy, 0);
        check("start_clear_fill", fill, 0);
        load_data = 32'hDEAD_BEEF; load_valid = 1'b1; clear = 1'b1; step();
        load_valid = 1'b0; clear = 1'b0;
        check("clear_beats_load", fill, 0);

        // Loop of 3 with stop after 5 accepted: 6 words then done.
        load_words(3, 32'h0005_0001, 32'h0001_0001);
        start_play(3, 1'b1);
        run_stream(3, 6, 0, 5, 60);
`ifdef BB_STREAMER_STATS_EN
        check("pass_cnt_stop", pass_cnt, 2);
`endif

        // Loop of 16 with random backpressure, three passes.
        do_clear();
        load_words(16, 32'h0F00_0100, 32'h0001_0003);
        start_play(16, 1'b1);
        run_stream(16, 48, 1, 40, 800);
`ifdef BB_STREAMER_STATS_EN
        check("pass_cnt_rand", pass_cnt, 3);
`endif

        // Asynchronous reset in the middle of playback.
        do_clear();
        load_words(4, 32'h1111_0000, 32'h1);
        start_play(4, 1'b1);
        out_ready = 1'b1;
        begin
            int w = 0;
            while (!out_valid && w < 6) begin
                step();
                w++;
            end
        end
        check("pre_reset_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_fill", fill, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        step();
        check("arst_done_hold", done, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_done", done, 0);
        check("post_rst_fill", fill, 0);
        load_words(4, 32'h2222_0000, 32'h0001_0001);
        start_play(4, 1'b0);
        run_stream(4, 4, 0, 0, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
